// File: rtl/vga_ellipse_gen.sv
// -----------------------------------------------------------------------------
// vga_ellipse_gen
//
// VGA timing generator with a multi-ellipse renderer. Each of NUM_ELL ellipses
// has a centre, two radii, an enable, a fill/outline mode and a colour. The
// lowest-indexed ellipse that covers a pixel sets its colour. Active pixels
// that no ellipse covers show BG_COLOR. Blanked pixels are driven to 0.
// Configuration writes go to a shadow bank. The shadow bank is copied to the
// active bank on the last cycle of each frame, so a frame is never torn.
//
// Optional feature: define VGA_ELL_OUTLINE_EN to honour the per-ellipse
// outline mode bit. When it is not defined, every enabled ellipse is filled
// and no inner-ellipse logic is built.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   cfg_wr     single-cycle register write strobe
//   cfg_addr   {ellipse index, field[1:0]}
//              field 0 = centre, field 1 = radii, field 2 = enable/mode/colour
//   cfg_wdata  write data
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   de         active-video flag
//   rgb        pixel colour, forced to 0 while de is 0
//
// hsync, vsync, de and rgb all leave the 3-stage pipeline together. They lag
// the internal counters by 3 clocks.
// -----------------------------------------------------------------------------
module vga_ellipse_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CW        = 11,
  parameter int RGB_W     = 16,
  parameter int NUM_ELL   = 2,
  parameter int OUTLINE_W = 4,
  parameter logic [RGB_W-1:0] BG_COLOR = RGB_W'(16'hFFFF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_wr,
  input  logic [$clog2(NUM_ELL)+1:0]   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         de,
  output logic [RGB_W-1:0]             rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(NUM_ELL) + 2;
  localparam int SW      = 2 * CW + 2;   // holds a square of a CW+1-bit magnitude
  localparam int PW      = 4 * CW + 4;   // full-width products and sums

  // ---------------------------------------------------------------------------
  // Timing counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          frame_end;

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign frame_end = h_last && (v_cnt == VW'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  logic de_raw, hs_raw, vs_raw;
  assign de_raw = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs_raw = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));

  logic [CW-1:0] x, y;
  assign x = CW'(h_cnt);
  assign y = CW'(v_cnt);

  // ---------------------------------------------------------------------------
  // Configuration: shadow bank (written by cfg port), active bank (frame copy)
  // ---------------------------------------------------------------------------
  logic [AW+1:0] addr_ext;
  logic [AW-1:0] wr_idx;
  logic [1:0]    wr_field;

  // Zero-extending first keeps the index slice legal when NUM_ELL is 1.
  assign addr_ext = {2'b00, cfg_addr};
  assign wr_idx   = addr_ext[AW+1:2];
  assign wr_field = cfg_addr[1:0];

  logic [CW-1:0]    sh_cx [NUM_ELL], sh_cy [NUM_ELL], sh_rx [NUM_ELL], sh_ry [NUM_ELL];
  logic [RGB_W-1:0] sh_col [NUM_ELL];
  logic [NUM_ELL-1:0] sh_en, sh_mode;

  logic [CW-1:0]    act_cx [NUM_ELL], act_cy [NUM_ELL], act_rx [NUM_ELL], act_ry [NUM_ELL];
  logic [RGB_W-1:0] act_col [NUM_ELL];
  logic [NUM_ELL-1:0] act_en, act_mode;

  // NOTE: the register banks are reset explicitly because every ellipse has to
  // power up disabled; they are flops here, not RAM, so reset is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en   <= '0;
      sh_mode <= '0;
      for (int i = 0; i < NUM_ELL; i++) begin
        sh_cx[i]  <= '0;
        sh_cy[i]  <= '0;
        sh_rx[i]  <= '0;
        sh_ry[i]  <= '0;
        sh_col[i] <= '0;
      end
    end else if (cfg_wr) begin
      // An index at or beyond NUM_ELL matches no i, so that write is dropped.
      for (int i = 0; i < NUM_ELL; i++) begin
        if (wr_idx == AW'(i)) begin
          case (wr_field)
            2'd0: begin
              sh_cx[i] <= cfg_wdata[0 +: CW];
              sh_cy[i] <= cfg_wdata[16 +: CW];
            end
            2'd1: begin
              sh_rx[i] <= cfg_wdata[0 +: CW];
              sh_ry[i] <= cfg_wdata[16 +: CW];
            end
            2'd2: begin
              sh_en[i]   <= cfg_wdata[31];
              sh_mode[i] <= cfg_wdata[30];
              sh_col[i]  <= cfg_wdata[RGB_W-1:0];
            end
            default: ;  // field 3 is reserved
          endcase
        end
      end
    end
  end

  // The copy reads the shadow bank before the edge, so a write on the
  // frame-end cycle misses this copy and appears one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_en   <= '0;
      act_mode <= '0;
      for (int i = 0; i < NUM_ELL; i++) begin
        act_cx[i]  <= '0;
        act_cy[i]  <= '0;
        act_rx[i]  <= '0;
        act_ry[i]  <= '0;
        act_col[i] <= '0;
      end
    end else if (frame_end) begin
      act_en   <= sh_en;
      act_mode <= sh_mode;
      act_cx   <= sh_cx;
      act_cy   <= sh_cy;
      act_rx   <= sh_rx;
      act_ry   <= sh_ry;
      act_col  <= sh_col;
    end
  end

  // Field bits that no register uses are collected here on purpose.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  // ---------------------------------------------------------------------------
  // Stage 1: offsets and squares
  // ---------------------------------------------------------------------------
  logic signed [CW:0] dx_c [NUM_ELL], dy_c [NUM_ELL];
  logic [CW:0]        adx_c [NUM_ELL], ady_c [NUM_ELL];
  logic [SW-1:0]      dx2_c [NUM_ELL], dy2_c [NUM_ELL], rx2_c [NUM_ELL], ry2_c [NUM_ELL];
  logic [NUM_ELL-1:0] ok_c;

  // NOTE: each combinational output is assigned a default before any
  // conditional logic, so no path can leave it holding a value (no latch).
  always_comb begin
    ok_c = '0;
    for (int i = 0; i < NUM_ELL; i++) begin
      dx_c[i]  = $signed({1'b0, x}) - $signed({1'b0, act_cx[i]});
      dy_c[i]  = $signed({1'b0, y}) - $signed({1'b0, act_cy[i]});
      adx_c[i] = dx_c[i][CW] ? $unsigned(-dx_c[i]) : $unsigned(dx_c[i]);
      ady_c[i] = dy_c[i][CW] ? $unsigned(-dy_c[i]) : $unsigned(dy_c[i]);
      dx2_c[i] = SW'(adx_c[i]) * SW'(adx_c[i]);
      dy2_c[i] = SW'(ady_c[i]) * SW'(ady_c[i]);
      rx2_c[i] = SW'(act_rx[i]) * SW'(act_rx[i]);
      ry2_c[i] = SW'(act_ry[i]) * SW'(act_ry[i]);
      ok_c[i]  = act_en[i] && (act_rx[i] != '0) && (act_ry[i] != '0);
    end
  end

  logic [SW-1:0]      dx2_s1 [NUM_ELL], dy2_s1 [NUM_ELL], rx2_s1 [NUM_ELL], ry2_s1 [NUM_ELL];
  logic [RGB_W-1:0]   col_s1 [NUM_ELL];
  logic [NUM_ELL-1:0] ok_s1;
  logic               de_s1, hs_s1, vs_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_s1 <= '0;
      de_s1 <= 1'b0;
      hs_s1 <= 1'b1;   // idle sync level, so no glitch after reset release
      vs_s1 <= 1'b1;
      for (int i = 0; i < NUM_ELL; i++) begin
        dx2_s1[i] <= '0;
        dy2_s1[i] <= '0;
        rx2_s1[i] <= '0;
        ry2_s1[i] <= '0;
        col_s1[i] <= '0;
      end
    end else begin
      ok_s1  <= ok_c;
      de_s1  <= de_raw;
      hs_s1  <= hs_raw;
      vs_s1  <= vs_raw;
      dx2_s1 <= dx2_c;
      dy2_s1 <= dy2_c;
      rx2_s1 <= rx2_c;
      ry2_s1 <= ry2_c;
      col_s1 <= act_col;
    end
  end

`ifdef VGA_ELL_OUTLINE_EN
  // Inner ellipse for outline mode. Radii saturate at 0. A zero inner radius
  // clears cut_c, so that ellipse is drawn as filled.
  logic [CW-1:0]      irx_c [NUM_ELL], iry_c [NUM_ELL];
  logic [SW-1:0]      irx2_c [NUM_ELL], iry2_c [NUM_ELL];
  logic [NUM_ELL-1:0] cut_c;

  always_comb begin
    cut_c = '0;
    for (int i = 0; i < NUM_ELL; i++) begin
      irx_c[i]  = (act_rx[i] > CW'(OUTLINE_W)) ? act_rx[i] - CW'(OUTLINE_W) : '0;
      iry_c[i]  = (act_ry[i] > CW'(OUTLINE_W)) ? act_ry[i] - CW'(OUTLINE_W) : '0;
      irx2_c[i] = SW'(irx_c[i]) * SW'(irx_c[i]);
      iry2_c[i] = SW'(iry_c[i]) * SW'(iry_c[i]);
      cut_c[i]  = act_mode[i] && (irx_c[i] != '0) && (iry_c[i] != '0);
    end
  end

  logic [SW-1:0]      irx2_s1 [NUM_ELL], iry2_s1 [NUM_ELL];
  logic [NUM_ELL-1:0] cut_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cut_s1 <= '0;
      for (int i = 0; i < NUM_ELL; i++) begin
        irx2_s1[i] <= '0;
        iry2_s1[i] <= '0;
      end
    end else begin
      cut_s1  <= cut_c;
      irx2_s1 <= irx2_c;
      iry2_s1 <= iry2_c;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^act_mode;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: full-width products and per-ellipse hit bits
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      lhs_c [NUM_ELL], rhs_c [NUM_ELL];
  logic [NUM_ELL-1:0] hit_c;
`ifdef VGA_ELL_OUTLINE_EN
  logic [PW-1:0]      ilhs_c [NUM_ELL], irhs_c [NUM_ELL];
`endif

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < NUM_ELL; i++) begin
      lhs_c[i] = PW'(dx2_s1[i]) * PW'(ry2_s1[i]) + PW'(dy2_s1[i]) * PW'(rx2_s1[i]);
      rhs_c[i] = PW'(rx2_s1[i]) * PW'(ry2_s1[i]);
      hit_c[i] = ok_s1[i] && (lhs_c[i] <= rhs_c[i]);
`ifdef VGA_ELL_OUTLINE_EN
      ilhs_c[i] = PW'(dx2_s1[i]) * PW'(iry2_s1[i]) + PW'(dy2_s1[i]) * PW'(irx2_s1[i]);
      irhs_c[i] = PW'(irx2_s1[i]) * PW'(iry2_s1[i]);
      if (cut_s1[i] && (ilhs_c[i] <= irhs_c[i])) hit_c[i] = 1'b0;
`endif
    end
  end

  logic [NUM_ELL-1:0] hit_s2;
  logic [RGB_W-1:0]   col_s2 [NUM_ELL];
  logic               de_s2, hs_s2, vs_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s2 <= '0;
      de_s2  <= 1'b0;
      hs_s2  <= 1'b1;
      vs_s2  <= 1'b1;
      for (int i = 0; i < NUM_ELL; i++) col_s2[i] <= '0;
    end else begin
      hit_s2 <= hit_c;
      de_s2  <= de_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      col_s2 <= col_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: priority mux (lowest index wins) into the output registers
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0] pix_c;

  always_comb begin
    pix_c = BG_COLOR;
    for (int i = NUM_ELL - 1; i >= 0; i--) begin
      if (hit_s2[i]) pix_c = col_s2[i];
    end
    if (!de_s2) pix_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      rgb   <= '0;
    end else begin
      hsync <= hs_s2;
      vsync <= vs_s2;
      de    <= de_s2;
      rgb   <= pix_c;
    end
  end

endmodule
